rf_wb_arbiter: RTL

Write-back arbiter and scoreboard for the 32x32 register file, which has one write port (a3/wd3/we3) and two read ports. It shares the single write port between two requesters, the ALU (port 0) and the load/store unit (port 1), using round-robin or fixed priority. It also keeps a per-register pending-write scoreboard so that issue logic can detect RAW hazards on the read addresses. It sits between the execute/memory stages and the register file write port.

---
 rtl/rf_wb_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the ALU (port 0)
// and the LSU (port 1), and keeps a pending-write scoreboard for RAW hazard checks.
// Latency: a grant at edge N drives the write-port outputs from the cycle after edge N.
// Backpressure: readyN is combinational; a requester holds valid/addr/data until it is granted.
//
// Ports:
//   clk_i, reset                        clock (rising edge), synchronous active-high reset
//   req0_* / req1_*                     valid/ready write-back requests (ALU, LSU)
//   issue_valid_i, issue_rd_i           issued instruction that will write issue_rd_i
//   a1_i, a2_i -> busy1_o, busy2_o      scoreboard lookups for the two read addresses
//   rf_a3_o, rf_wd3_o, rf_we3_o         register-file write port
//   pending_o                           full scoreboard vector (debug)

module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit RR_EN  = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset,

  input  logic                 req0_valid_i,
  output logic                 req0_ready_o,
  input  logic [ADDR_W-1:0]    req0_addr_i,
  input  logic [DATA_W-1:0]    req0_data_i,

  input  logic                 req1_valid_i,
  output logic                 req1_ready_o,
  input  logic [ADDR_W-1:0]    req1_addr_i,
  input  logic [DATA_W-1:0]    req1_data_i,

  input  logic                 issue_valid_i,
  input  logic [ADDR_W-1:0]    issue_rd_i,

  input  logic [ADDR_W-1:0]    a1_i,
  input  logic [ADDR_W-1:0]    a2_i,
  output logic                 busy1_o,
  output logic                 busy2_o,

  output logic [ADDR_W-1:0]    rf_a3_o,
  output logic [DATA_W-1:0]    rf_wd3_o,
  output logic                 rf_we3_o,

  output logic [2**ADDR_W-1:0] pending_o
);

  localparam int NREG = 2**ADDR_W;

  // One write-back transaction: destination register plus data.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic            rr_ptr;        // port preferred when both request
  logic [NREG-1:0] pending;       // scoreboard: write outstanding per register
  wb_t             out_wb;        // registered write-port address/data
  logic            out_we;        // registered write-port enable

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic gnt0;
  logic gnt1;
  logic any_gnt;
  wb_t  req0_wb;
  wb_t  req1_wb;
  wb_t  win_wb;

  assign req0_wb = '{addr: req0_addr_i, data: req0_data_i};
  assign req1_wb = '{addr: req1_addr_i, data: req1_data_i};

  // Reset forces both grants low so nothing is accepted (or cleared in the
  // scoreboard) while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0_valid_i && req1_valid_i) begin
        // Fixed priority collapses to "port 0 always wins".
        if (RR_EN && rr_ptr) begin
          gnt1 = 1'b1;
        end else begin
          gnt0 = 1'b1;
        end
      end else if (req0_valid_i) begin
        gnt0 = 1'b1;
      end else if (req1_valid_i) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign any_gnt      = gnt0 | gnt1;
  assign win_wb       = gnt1 ? req1_wb : req0_wb;
  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  // After serving port k the other port becomes preferred; idle cycles hold.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      rr_ptr <= 1'b0;
    end else if (any_gnt) begin
      rr_ptr <= ~gnt1;
    end
  end

  // --------------------------------------------------------------------------
  // Register-file write port
  // --------------------------------------------------------------------------
  // A grant to register 0 completes the handshake but never writes, because
  // register 0 is hard-wired to zero. Address/data hold when idle so the
  // write port does not toggle needlessly.
  always_ff @(posedge clk_i) begin
    if (reset) begin
      out_we <= 1'b0;
      out_wb <= '0;
    end else begin
      out_we <= any_gnt && (win_wb.addr != '0);
      if (any_gnt) begin
        out_wb <= win_wb;
      end
    end
  end

  assign rf_we3_o = out_we;
  assign rf_a3_o  = out_wb.addr;
  assign rf_wd3_o = out_wb.data;

  // --------------------------------------------------------------------------
  // Pending-write scoreboard
  // --------------------------------------------------------------------------
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] pending_nxt;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid_i) begin
      set_vec[issue_rd_i] = 1'b1;
    end
    // Cleared at the grant, not at the later register-file write, so the
    // bypass/issue logic sees the register as free one cycle earlier.
    if (any_gnt) begin
      clr_vec[win_wb.addr] = 1'b1;
    end
    // A same-edge issue means a newer writer is in flight: set beats clear.
    pending_nxt    = (pending & ~clr_vec) | set_vec;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign pending_o = pending;

  // Lookups reflect the registered state only; a grant in the current cycle
  // is not forwarded. pending[0] is always 0, so querying r0 is never busy.
  assign busy1_o = pending[a1_i];
  assign busy2_o = pending[a2_i];

endmodule
